// File: rtl/lcd_driver_pkg.sv
// Shared definitions for the character LCD driver: panel command bytes,
// controller state encoding, line geometry and the init command table.
package lcd_driver_pkg;

    // Controller states, from power-up through per-byte write handshakes
    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        IDLE     = 3'd2,
        SETUP    = 3'd3,
        PULSE    = 3'd4,
        WAIT     = 3'd5
    } lcdState_e;

    // HD44780-style command bytes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow)
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_HOME     = 8'h80;  // DDRAM address 0x00 (line 1)
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40 (line 2)

    // Visible characters per line and character FIFO depth
    localparam int unsigned LINE_LEN   = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    // Index of the last command in the init table
    localparam logic [1:0] INIT_LAST = 2'd3;

    // Init command table, issued in index order after power-up
    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Small first-word-fall-through FIFO buffering characters between the
// message source and the LCD write sequencer. Pushes into a full FIFO and
// pops from an empty FIFO are ignored.
module lcd_char_fifo
    import lcd_driver_pkg::*;
(
    input  logic       clk,
    input  logic       reset_not,
    input  logic       push_i,
    input  logic [7:0] pushData_i,
    input  logic       pop_i,
    output logic [7:0] popData_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             doPush;
    logic             doPop;

    assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;
    assign popData_o = mem_q[rdPtr_q];

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lcd_driver.sv
// Character LCD driver: buffers strobed ASCII characters in a small FIFO,
// runs the power-up wait and init command sequence, then writes each
// character to the panel with SETUP/PULSE/WAIT timing and moves the cursor
// to line 2 or back home when a line fills up.
module lcd_driver
    import lcd_driver_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC  = 20,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 85000,
    parameter int unsigned PWR_WAIT_CYC = 750000
) (
    input  logic       clk,
    input  logic       reset_not,
    input  logic [7:0] lcd_data,
    input  logic       lcd_enable,
    output logic       ready,
    output logic       overflow,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DB
);

    lcdState_e   state_q,      state_d;
    logic [31:0] cnt_q,        cnt_d;
    logic [1:0]  initIdx_q,    initIdx_d;
    logic        initActive_q, initActive_d;
    logic [4:0]  pos_q,        pos_d;
    logic        pend_q,       pend_d;
    logic [7:0]  pendCmd_q,    pendCmd_d;
    logic        rs_q,         rs_d;
    logic [7:0]  db_q,         db_d;
    logic        e_q,          e_d;
    logic        enPrev_q;
    logic        overflow_q;

    logic        strobeEdge;
    logic        fifoPush;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [7:0]  fifoData;
    logic [31:0] waitLen;

    // A character arrives on a 0->1 transition of the strobe
    assign strobeEdge = lcd_enable && !enPrev_q;
    assign fifoPush   = strobeEdge && !fifoFull;

    // Clear needs a much longer settle time than any other write
    assign waitLen = (!rs_q && (db_q == CMD_CLEAR)) ? CLR_WAIT_CYC : CMD_WAIT_CYC;

    assign ready    = !fifoFull;
    assign overflow = overflow_q;
    assign LCD_E    = e_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DB   = db_q;

    lcd_char_fifo u_fifo (
        .clk        (clk),
        .reset_not  (reset_not),
        .push_i     (fifoPush),
        .pushData_i (lcd_data),
        .pop_i      (fifoPop),
        .popData_o  (fifoData),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Strobe edge detector and sticky drop flag
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            enPrev_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            enPrev_q <= lcd_enable;
            if (strobeEdge && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Sequencer next state: power-up, init table, then FIFO drain with cursor wrap
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        initIdx_d    = initIdx_q;
        initActive_d = initActive_q;
        pos_d        = pos_q;
        pend_d       = pend_q;
        pendCmd_d    = pendCmd_q;
        rs_d         = rs_q;
        db_d         = db_q;
        fifoPop      = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q >= PWR_WAIT_CYC - 32'd1) begin
                    state_d      = INIT;
                    cnt_d        = '0;
                    initIdx_d    = '0;
                    initActive_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            INIT: begin
                rs_d    = 1'b0;
                db_d    = initCmd(initIdx_q);
                state_d = SETUP;
            end

            IDLE: begin
                if (pend_q) begin
                    rs_d    = 1'b0;
                    db_d    = pendCmd_q;
                    pend_d  = 1'b0;
                    state_d = SETUP;
                end else if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    rs_d    = 1'b1;
                    db_d    = fifoData;
                    pos_d   = pos_q + 5'd1;
                    if (pos_q == 5'(LINE_LEN - 1)) begin
                        pend_d    = 1'b1;
                        pendCmd_d = CMD_LINE2;
                    end else if (pos_q == 5'(2 * LINE_LEN - 1)) begin
                        pend_d    = 1'b1;
                        pendCmd_d = CMD_HOME;
                    end
                    state_d = SETUP;
                end
            end

            SETUP: begin
                cnt_d   = '0;
                state_d = PULSE;
            end

            PULSE: begin
                if (cnt_q >= E_PULSE_CYC - 32'd1) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            WAIT: begin
                if (cnt_q >= waitLen - 32'd1) begin
                    cnt_d = '0;
                    if (initActive_q && (initIdx_q != INIT_LAST)) begin
                        initIdx_d = initIdx_q + 2'd1;
                        state_d   = INIT;
                    end else begin
                        initActive_d = 1'b0;
                        state_d      = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        e_d = (state_d == PULSE);
    end

    // Sequencer registers; reset drops E at once and restarts power-up
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            initIdx_q    <= '0;
            initActive_q <= 1'b0;
            pos_q        <= '0;
            pend_q       <= 1'b0;
            pendCmd_q    <= 8'h00;
            rs_q         <= 1'b0;
            db_q         <= 8'h00;
            e_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            initIdx_q    <= initIdx_d;
            initActive_q <= initActive_d;
            pos_q        <= pos_d;
            pend_q       <= pend_d;
            pendCmd_q    <= pendCmd_d;
            rs_q         <= rs_d;
            db_q         <= db_d;
            e_q          <= e_d;
        end
    end

endmodule

// File: tb/tb_lcd_driver.sv
// Scoreboard bench for lcd_driver: stimulus pushes the panel writes it
// expects, a negedge monitor pops one per E pulse and checks data, pulse
// width, gaps and bus stability.
module tb_lcd_driver;

    localparam int unsigned E_CYC   = 2;
    localparam int unsigned CMD_CYC = 4;
    localparam int unsigned CLR_CYC = 8;
    localparam int unsigned PWR_CYC = 10;

    logic       clk = 1'b0;
    logic       reset_not;
    logic [7:0] lcd_data;
    logic       lcd_enable;
    logic       ready;
    logic       overflow;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DB;

    lcd_driver #(
        .E_PULSE_CYC  (E_CYC),
        .CMD_WAIT_CYC (CMD_CYC),
        .CLR_WAIT_CYC (CLR_CYC),
        .PWR_WAIT_CYC (PWR_CYC)
    ) dut (
        .clk        (clk),
        .reset_not  (reset_not),
        .lcd_data   (lcd_data),
        .lcd_enable (lcd_enable),
        .ready      (ready),
        .overflow   (overflow),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_DB     (LCD_DB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        bit         chained;
    } pulse_t;

    pulse_t expQ[$];
    int     checks = 0;
    int     fails  = 0;
    int     modelPos = 0;
    int     modelCnt = 0;
    bit     modelOvf = 1'b0;
    bit     preInit  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Reference model: one RS=1 write per accepted char, cursor commands at line ends
    function automatic void expectChar(input logic [7:0] ch);
        expQ.push_back('{rs: 1'b1, db: ch, chained: 1'b0});
        modelPos++;
        if (modelPos == 16) begin
            expQ.push_back('{rs: 1'b0, db: 8'hC0, chained: 1'b1});
        end else if (modelPos == 32) begin
            expQ.push_back('{rs: 1'b0, db: 8'h80, chained: 1'b1});
            modelPos = 0;
        end
    endfunction

    function automatic void expectInit();
        expQ.delete();
        expQ.push_back('{rs: 1'b0, db: 8'h38, chained: 1'b0});
        expQ.push_back('{rs: 1'b0, db: 8'h0C, chained: 1'b1});
        expQ.push_back('{rs: 1'b0, db: 8'h01, chained: 1'b1});
        expQ.push_back('{rs: 1'b0, db: 8'h06, chained: 1'b1});
        modelPos = 0;
    endfunction

    // One strobe: enable high for one cycle, then low
    task automatic applyStimulus(input logic [7:0] ch);
        if (preInit) begin
            if (modelCnt < 4) begin
                modelCnt++;
                expectChar(ch);
            end else begin
                modelOvf = 1'b1;
            end
        end else begin
            expectChar(ch);
        end
        @(negedge clk); #1;
        lcd_data   = ch;
        lcd_enable = 1'b1;
        @(negedge clk); #1;
        lcd_enable = 1'b0;
        lcd_data   = 8'($urandom);
        if (preInit) begin
            checkOutput("ready_vs_fill", ready, 32'(modelCnt < 4));
        end
        checkOutput("overflow_flag", overflow, 32'(modelOvf));
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || LCD_E) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            fails++;
            $display("[TB] FAIL drain_timeout: %0d writes still pending after %0d cycles", expQ.size(), n);
        end
    endtask

    task automatic sendRandom(input int total);
        int sent = 0;
        while (sent < total) begin
            int batch;
            batch = int'($urandom_range(1, 4));
            if (batch > total - sent) batch = total - sent;
            for (int i = 0; i < batch; i++) begin
                applyStimulus(8'($urandom_range(32, 126)));
            end
            sent += batch;
            waitDrain(400);
        end
    endtask

    // Monitor: sample away from the rising edge and score each E pulse
    int     lowCnt    = 0;
    int     highCnt   = 0;
    int     lastWait  = 0;
    bit     prevE     = 1'b0;
    bit     firstPulse = 1'b1;
    bit     havePulse = 1'b0;
    pulse_t cur;

    always @(negedge clk) begin
        if (!reset_not) begin
            checkOutput("reset_E", LCD_E, 0);
            checkOutput("reset_RS", LCD_RS, 0);
            checkOutput("reset_RW", LCD_RW, 0);
            checkOutput("reset_DB", LCD_DB, 0);
            checkOutput("reset_ready", ready, 1);
            checkOutput("reset_overflow", overflow, 0);
            prevE      = 1'b0;
            lowCnt     = 0;
            highCnt    = 0;
            firstPulse = 1'b1;
            havePulse  = 1'b0;
        end else begin
            checkOutput("rw_low", LCD_RW, 0);
            if (LCD_E && !prevE) begin
                checks++;
                if (expQ.size() == 0) begin
                    fails++;
                    havePulse = 1'b0;
                    $display("[TB] FAIL unexpected_pulse: got RS=%0b DB=0x%0h, expected no write", LCD_RS, LCD_DB);
                end else begin
                    cur = expQ.pop_front();
                    havePulse = 1'b1;
                    checkOutput("pulse_rs", LCD_RS, 32'(cur.rs));
                    checkOutput("pulse_db", LCD_DB, 32'(cur.db));
                    if (firstPulse)
                        checkRange("powerup_gap", lowCnt, int'(PWR_CYC), int'(PWR_CYC) + 4);
                    else if (cur.chained)
                        checkRange("chained_gap", lowCnt, lastWait + 1, lastWait + 3);
                    else
                        checkRange("min_gap", lowCnt, lastWait + 1, 1 << 30);
                    lastWait = (!cur.rs && cur.db == 8'h01) ? int'(CLR_CYC) : int'(CMD_CYC);
                end
                firstPulse = 1'b0;
                highCnt    = 1;
            end else if (LCD_E) begin
                highCnt++;
                if (havePulse) begin
                    checkOutput("stable_rs", LCD_RS, 32'(cur.rs));
                    checkOutput("stable_db", LCD_DB, 32'(cur.db));
                end
            end else if (prevE) begin
                checkOutput("e_width", 32'(highCnt), 32'(E_CYC));
                lowCnt = 1;
            end else begin
                lowCnt++;
            end
            prevE = LCD_E;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] msg [7];

    initial begin
        int n;
        msg = '{8'h53, 8'h75, 8'h63, 8'h63, 8'h65, 8'h73, 8'h73};
        reset_not  = 1'b0;
        lcd_enable = 1'b0;
        lcd_data   = 8'h00;
        repeat (3) @(negedge clk);

        // Power-up, init, and a 6-strobe burst that overfills the FIFO before any pop
        expectInit();
        preInit  = 1'b1;
        modelCnt = 0;
        modelOvf = 1'b0;
        #1 reset_not = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom_range(32, 126)));
        preInit = 1'b0;
        waitDrain(600);
        $display("[TB] init and overflow burst done");

        // "Success" in two batches that fit the FIFO
        for (int i = 0; i < 7; i++) begin
            applyStimulus(msg[i]);
            if (i == 3) waitDrain(400);
        end
        waitDrain(400);

        // Strobe held high for 20 cycles is a single character
        expectChar(8'h5A);
        @(negedge clk); #1;
        lcd_data   = 8'h5A;
        lcd_enable = 1'b1;
        repeat (20) @(negedge clk);
        #1 lcd_enable = 1'b0;
        waitDrain(400);

        // Enough characters to cross both line boundaries
        sendRandom(25);
        $display("[TB] line wrap pass done");

        // Reset while E is high
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        n = 0;
        while (!LCD_E && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("e_high_before_reset", LCD_E, 1);
        #1 reset_not = 1'b0;
        #1;
        checkOutput("e_async_clear", LCD_E, 0);
        checkOutput("db_async_clear", LCD_DB, 0);
        expQ.delete();
        modelOvf = 1'b0;
        repeat (3) @(negedge clk);
        expectInit();
        #1 reset_not = 1'b1;
        waitDrain(600);

        // 17 characters after re-init: line-2 command after the 16th
        sendRandom(17);

        repeat (60) @(negedge clk);
        checkOutput("queue_empty_at_end", 32'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
